// File: rtl/mdu_issue_ctrl.sv
// mdu_issue_ctrl: issue/hazard controller in front of the multiply/divide unit.
// Gates the MDU start, mirrors the MDU busy window with a local countdown,
// raises the D-stage stall for MDU hazards and latches a sticky error when an
// E-stage compute op arrives while the unit is still busy.
module mdu_issue_ctrl #(
  parameter int MUL_LAT = 5,   // busy cycles after MULT/MULTU start, 1..15
  parameter int DIV_LAT = 10   // busy cycles after DIV/DIVU start, 1..15
) (
  input  logic       clk,
  input  logic       reset,     // async, active low
  input  logic       E_Valid,
  input  logic [3:0] E_MDUOp,
  input  logic [3:0] D_MDUOp,
  input  logic       IntReq,
  input  logic       ERET,
  output logic       MDU_Start,
  output logic [3:0] MDU_Op,
  output logic       Busy,
  output logic       Stall,
  output logic       Err
);

  // Op encoding shared by the E and D stages; 9..15 decode as NONE.
  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  // Countdown reload values; the counter is 4 bits so latencies cap at 15.
  localparam logic [3:0] MUL_CNT = 4'(MUL_LAT);
  localparam logic [3:0] DIV_CNT = 4'(DIV_LAT);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t     state;
  logic [3:0] cnt;

  logic e_mul, e_div, e_compute, e_move, e_any;
  logic d_any;
  logic issue_ok;

  // Op-class decode for the E and D stages.
  always_comb begin
    e_mul     = (E_MDUOp == OP_MULT) || (E_MDUOp == OP_MULTU);
    e_div     = (E_MDUOp == OP_DIV)  || (E_MDUOp == OP_DIVU);
    e_compute = e_mul || e_div;
    e_move    = (E_MDUOp >= OP_MFHI) && (E_MDUOp <= OP_MTLO);
    e_any     = e_compute || e_move;
    d_any     = (D_MDUOp != OP_NONE) && (D_MDUOp <= OP_MTLO);
  end

  assign Busy = (state == RUN);

  // A compute op may start only when the unit is idle and no interrupt/ERET
  // is flushing the pipe; the reset term keeps Start quiet while held in reset.
  assign issue_ok  = reset & E_Valid & e_compute & ~Busy & ~IntReq & ~ERET;
  assign MDU_Start = issue_ok;

  // Moves are forwarded even under IntReq/ERET; the MDU suppresses the write.
  assign MDU_Op = (E_Valid && e_any) ? E_MDUOp : OP_NONE;

  // Any MDU op in D must wait while the unit is busy or is being started now,
  // so MFHI/MFLO never read stale HI/LO.
  assign Stall = d_any & (Busy | MDU_Start);

  // Busy-window FSM with countdown, plus the sticky back-to-back error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
      Err   <= 1'b0;
    end else begin
      // An issue attempt while busy means the upstream stall was ignored.
      if (E_Valid && e_compute && Busy)
        Err <= 1'b1;
      case (state)
        IDLE: begin
          if (issue_ok) begin
            state <= RUN;
            cnt   <= e_mul ? MUL_CNT : DIV_CNT;
          end
        end
        RUN: begin
          // Interrupts never cancel an in-flight op; the countdown just runs out.
          if (cnt == 4'd1) begin
            state <= IDLE;
            cnt   <= 4'd0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

endmodule
